// File: rtl/mux_8to1.sv
// mux_8to1: 8:1 bit mux, combinational y plus registered y_q/s_q and change pulse chg (async reset rst)
module mux_8to1 (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] i,
  input  logic [2:0] s,
  input  logic       en,
  output logic       y,
  output logic       y_q,
  output logic [2:0] s_q,
  output logic       chg
);
  assign y = i[s];
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      y_q <= 1'b0;
      s_q <= 3'd0;
      chg <= 1'b0;
    end else begin
      chg <= en & (y != y_q);
      if (en) begin
        y_q <= y;
        s_q <= s;
      end
    end
endmodule

// File: tb/tb_mux_8to1.sv
// tb_mux_8to1: directed self-checking bench for mux_8to1
module tb_mux_8to1;
  logic       clk;
  logic       rst;
  logic [7:0] i;
  logic [2:0] s;
  logic       en;
  logic       y;
  logic       y_q;
  logic [2:0] s_q;
  logic       chg;
  int n_assert = 0;
  int n_fail = 0;
  mux_8to1 dut (
    .clk(clk),
    .rst(rst),
    .i(i),
    .s(s),
    .en(en),
    .y(y),
    .y_q(y_q),
    .s_q(s_q),
    .chg(chg)
  );
  initial clk = 1'b0;
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic regs(input string tag, input logic yq, input logic [2:0] sq, input logic c);
    chk({tag, "_y_q"}, {7'd0, y_q}, {7'd0, yq});
    chk({tag, "_s_q"}, {5'd0, s_q}, {5'd0, sq});
    chk({tag, "_chg"}, {7'd0, chg}, {7'd0, c});
  endtask
  initial begin
    logic [2:0] sv [8];
    logic       yv [8];
    sv = '{3'd0, 3'd6, 3'd4, 3'd7, 3'd2, 3'd5, 3'd3, 3'd1};
    yv = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1};
    rst = 1'b1;
    en = 1'b1;
    i = 8'h00;
    s = 3'd0;
    #1;
    regs("reset", 1'b0, 3'd0, 1'b0);
    i = 8'b1101_0110;
    for (int k = 0; k < 8; k++) begin
      s = sv[k];
      #1;
      chk($sformatf("y_walk_s%0d", sv[k]), {7'd0, y}, {7'd0, yv[k]});
      #4;
    end
    for (int a = 0; a < 256; a++)
      for (int b = 0; b < 8; b++) begin
        i = a[7:0];
        s = b[2:0];
        #1;
        chk($sformatf("y_exh_%0h_%0d", a, b), {7'd0, y}, {7'd0, a[b]});
      end
    en = 1'b1;
    i = 8'h80;
    s = 3'd7;
    @(negedge clk);
    rst = 1'b0;
    regs("held_in_reset", 1'b0, 3'd0, 1'b0);
    step();
    regs("cap_s7", 1'b1, 3'd7, 1'b1);
    step();
    regs("hold_s7", 1'b1, 3'd7, 1'b0);
    s = 3'd0;
    step();
    regs("cap_s0", 1'b0, 3'd0, 1'b1);
    step();
    regs("hold_s0", 1'b0, 3'd0, 1'b0);
    s = 3'd7;
    step();
    regs("wrap_s7", 1'b1, 3'd7, 1'b1);
    #2;
    rst = 1'b1;
    #1;
    regs("async_rst", 1'b0, 3'd0, 1'b0);
    chk("y_during_rst", {7'd0, y}, 8'd1);
    rst = 1'b0;
    #1;
    regs("after_rst_pre_edge", 1'b0, 3'd0, 1'b0);
    step();
    regs("first_cap_after_rst", 1'b1, 3'd7, 1'b1);
    en = 1'b0;
    i = 8'h00;
    s = 3'd3;
    step();
    regs("en0_c1", 1'b1, 3'd7, 1'b0);
    i = 8'hFF;
    s = 3'd5;
    step();
    regs("en0_c2", 1'b1, 3'd7, 1'b0);
    i = 8'h00;
    s = 3'd2;
    step();
    regs("en0_c3", 1'b1, 3'd7, 1'b0);
    en = 1'b1;
    step();
    regs("reenable", 1'b0, 3'd2, 1'b1);
    i = 8'h20;
    s = 3'd5;
    step();
    regs("simul_change", 1'b1, 3'd5, 1'b1);
    i = 8'hDF;
    s = 3'd1;
    step();
    regs("same_value", 1'b1, 3'd1, 1'b0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
